tag_match_encoder: RTL and testbench

- Tag-lookup front end of the L2 cache.
- Compares the request address tag against the stored tag of every way in the indexed set, masks out Invalid lines, and one-hot-to-binary encodes the matching way.
- Registers hit, way number, match vector and the hit line's MESI state for the LRU/data-path control logic.
- The set-read (storage indexing) happens upstream; this block sees only the selected set's tags and MESI bits.

---
 rtl/l2_cache_pkg.sv | 12 +
 rtl/tag_eq_cmp.sv | 12 +
 rtl/tag_match_encoder.sv | 81 ++++++++
 tb/tb_tag_match_encoder.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/l2_cache_pkg.sv
// rtl/l2_cache_pkg.sv - shared L2 cache constants: MESI encodings and default tag-lookup geometry
package l2_cache_pkg;

  localparam logic [3:0] MESI_M = 4'b0001;
  localparam logic [3:0] MESI_E = 4'b0010;
  localparam logic [3:0] MESI_S = 4'b0100;
  localparam logic [3:0] MESI_I = 4'b1000;

  localparam int DEF_TAG_BITS = 12;
  localparam int DEF_WAYS     = 8;

endpackage

// File: rtl/tag_eq_cmp.sv
// rtl/tag_eq_cmp.sv - full-width equality compare of one stored tag against the request tag
module tag_eq_cmp #(
  parameter int TAG_BITS = 12
) (
  input  logic [TAG_BITS-1:0] a,
  input  logic [TAG_BITS-1:0] b,
  output logic                eq
);

  assign eq = (a == b);

endmodule

// File: rtl/tag_match_encoder.sv
// rtl/tag_match_encoder.sv - per-way tag compare, Invalid masking, priority encode and registered hit result
module tag_match_encoder
  import l2_cache_pkg::*;
#(
  parameter  int TAG_BITS = DEF_TAG_BITS,
  parameter  int WAYS     = DEF_WAYS,
  localparam int WAY_BITS = $clog2(WAYS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     lookup_valid,
  input  logic [TAG_BITS-1:0]      addr_tag,
  input  logic [WAYS*TAG_BITS-1:0] way_tags,
  input  logic [WAYS*4-1:0]        way_mesi,
  output logic                     result_valid,
  output logic                     hit,
  output logic [WAY_BITS-1:0]      hit_way,
  output logic [WAYS-1:0]          match_vec,
  output logic                     multi_hit,
  output logic [3:0]               hit_mesi
);

  logic [WAYS-1:0]     raw;
  logic [WAYS-1:0]     match;
  logic [WAY_BITS-1:0] enc_way;
  logic [3:0]          sel_mesi;
  logic [WAY_BITS:0]   match_cnt;
  logic                any_match;

  for (genvar i = 0; i < WAYS; i++) begin : g_way
    tag_eq_cmp #(.TAG_BITS(TAG_BITS)) u_cmp (
      .a  (way_tags[i*TAG_BITS +: TAG_BITS]),
      .b  (addr_tag),
      .eq (raw[i])
    );
    // Bit 3 alone decides validity, so malformed MESI codes still participate.
    assign match[i] = raw[i] & ~way_mesi[i*4+3];
  end

  assign any_match = |match;

  // Descending scan so the lowest-numbered matching way wins.
  always_comb begin
    enc_way  = '0;
    sel_mesi = MESI_I;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (match[i]) begin
        enc_way  = WAY_BITS'(i);
        sel_mesi = way_mesi[i*4 +: 4];
      end
    end
  end

  always_comb begin
    match_cnt = '0;
    for (int i = 0; i < WAYS; i++) begin
      match_cnt = match_cnt + {{WAY_BITS{1'b0}}, match[i]};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_valid <= 1'b0;
      hit          <= 1'b0;
      hit_way      <= '0;
      match_vec    <= '0;
      multi_hit    <= 1'b0;
      hit_mesi     <= MESI_I;
    end else if (lookup_valid) begin
      result_valid <= 1'b1;
      hit          <= any_match;
      hit_way      <= enc_way;
      match_vec    <= match;
      multi_hit    <= (match_cnt >= 2);
      hit_mesi     <= sel_mesi;
    end else begin
      result_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tag_match_encoder.sv
// tb/tb_tag_match_encoder.sv - directed bench for tag_match_encoder with hand-computed expectations
module tb_tag_match_encoder;

  localparam int TB = 12;
  localparam int NW = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             lookup_valid = 1'b0;
  logic [TB-1:0]    addr_tag = '0;
  logic [NW*TB-1:0] way_tags = '0;
  logic [NW*4-1:0]  way_mesi = '0;
  logic             result_valid;
  logic             hit;
  logic [2:0]       hit_way;
  logic [NW-1:0]    match_vec;
  logic             multi_hit;
  logic [3:0]       hit_mesi;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  tag_match_encoder dut (
    .clk          (clk),
    .reset        (reset),
    .lookup_valid (lookup_valid),
    .addr_tag     (addr_tag),
    .way_tags     (way_tags),
    .way_mesi     (way_mesi),
    .result_valid (result_valid),
    .hit          (hit),
    .hit_way      (hit_way),
    .match_vec    (match_vec),
    .multi_hit    (multi_hit),
    .hit_mesi     (hit_mesi)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic rv, input logic h, input logic [2:0] w,
                           input logic [7:0] mv, input logic mh, input logic [3:0] ms);
    check({tag, ".result_valid"}, 32'(result_valid), 32'(rv));
    check({tag, ".hit"},          32'(hit),          32'(h));
    check({tag, ".hit_way"},      32'(hit_way),      32'(w));
    check({tag, ".match_vec"},    32'(match_vec),    32'(mv));
    check({tag, ".multi_hit"},    32'(multi_hit),    32'(mh));
    check({tag, ".hit_mesi"},     32'(hit_mesi),     32'(ms));
  endtask

  task automatic fill(input logic [TB-1:0] t, input logic [3:0] m);
    for (int i = 0; i < NW; i++) begin
      way_tags[i*TB +: TB] = t;
      way_mesi[i*4 +: 4]   = m;
    end
  endtask

  task automatic set_way(input int i, input logic [TB-1:0] t, input logic [3:0] m);
    way_tags[i*TB +: TB] = t;
    way_mesi[i*4 +: 4]   = m;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset with a hitting lookup presented
    fill(12'h000, 4'b0010);
    set_way(3, 12'h3A3, 4'b0001);
    addr_tag     = 12'h3A3;
    lookup_valid = 1'b1;
    reset        = 1'b1;
    step();
    step();
    check_all("reset", 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 4'b1000);
    @(negedge clk);
    reset        = 1'b0;
    lookup_valid = 1'b0;
    step();
    check_all("post_reset_idle", 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 4'b1000);

    // single hit
    fill(12'h000, 4'b0010);
    set_way(5, 12'hABC, 4'b0100);
    addr_tag     = 12'hABC;
    lookup_valid = 1'b1;
    step();
    check_all("single_hit", 1'b1, 1'b1, 3'd5, 8'b0010_0000, 1'b0, 4'b0100);

    // Invalid mask
    set_way(5, 12'hABC, 4'b1000);
    step();
    check_all("invalid_mask", 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 4'b1000);

    // multi-hit priority
    fill(12'h000, 4'b0010);
    set_way(2, 12'h123, 4'b0001);
    set_way(6, 12'h123, 4'b0001);
    addr_tag = 12'h123;
    step();
    check_all("multi_hit", 1'b1, 1'b1, 3'd2, 8'b0100_0100, 1'b1, 4'b0001);

    // pipelining: A hits way 7, B misses, then idle
    fill(12'h000, 4'b0010);
    set_way(7, 12'h777, 4'b0010);
    addr_tag = 12'h777;
    step();
    check_all("pipe_a", 1'b1, 1'b1, 3'd7, 8'b1000_0000, 1'b0, 4'b0010);
    addr_tag = 12'h555;
    step();
    check_all("pipe_b", 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 4'b1000);
    lookup_valid = 1'b0;
    addr_tag     = 12'h777;
    step();
    check_all("pipe_hold", 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 4'b1000);

    // boundary tag all-ones at way 0, then one-bit-off tag
    fill(12'h000, 4'b0010);
    set_way(0, 12'hFFF, 4'b0010);
    addr_tag     = 12'hFFF;
    lookup_valid = 1'b1;
    step();
    check_all("tag_fff", 1'b1, 1'b1, 3'd0, 8'b0000_0001, 1'b0, 4'b0010);
    addr_tag = 12'hFFE;
    step();
    check_all("tag_ffe", 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 4'b1000);

    // illegal MESI: bit 3 clear still hits and passes through; bit 3 set masks
    fill(12'h000, 4'b0010);
    set_way(3, 12'h5A5, 4'b0110);
    set_way(4, 12'h5A5, 4'b1001);
    addr_tag = 12'h5A5;
    step();
    check_all("illegal_mesi", 1'b1, 1'b1, 3'd3, 8'b0000_1000, 1'b0, 4'b0110);

    // hold after a hit while lookup_valid is low and inputs change
    lookup_valid = 1'b0;
    addr_tag     = 12'h000;
    step();
    check_all("hold_hit", 1'b0, 1'b1, 3'd3, 8'b0000_1000, 1'b0, 4'b0110);

    // asynchronous reset mid-cycle clears without a clock edge
    lookup_valid = 1'b1;
    addr_tag     = 12'h5A5;
    step();
    check("pre_async.hit", 32'(hit), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_all("async_reset", 1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 4'b1000);
    @(negedge clk);
    reset        = 1'b0;
    lookup_valid = 1'b0;
    step();
    check("after_async.result_valid", 32'(result_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
